// File: rtl/hyperbus_ca_seq.sv
// HyperBus command/address sequencer: drives the 48-bit CA word, waits out the initial latency,
// then streams write bytes or captures read bytes for one chip select, followed by CS recovery.
module hyperbus_ca_seq #(
  parameter int unsigned MODULES    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LATENCY    = 6,
  parameter int unsigned RECOVERY   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [MODULES-1:0]    cs_mask_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  rw_i,
  input  logic [7:0]            len_i,
  input  logic [7:0]            wdata_i,
  output logic                  wready_o,
  output logic [7:0]            rdata_o,
  output logic                  rvalid_o,
  output logic [MODULES-1:0]    hb_cs_n_o,
  output logic [7:0]            hb_dq_o,
  output logic                  hb_dq_oe_o,
  input  logic [7:0]            hb_dq_i,
  input  logic                  hb_rwds_i,
  output logic                  busy_o
);

  typedef enum logic [2:0] {StIdle, StCa, StLat, StData, StRecov} state_e;

  localparam logic [7:0] CaLast    = 8'd5;
  localparam logic [7:0] LatLast   = 8'(LATENCY - 1);
  localparam logic [7:0] Lat2Last  = 8'(2 * LATENCY - 1);
  localparam logic [7:0] RecovLast = 8'(RECOVERY - 1);

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [MODULES-1:0]   hb_cs_n_q, hb_cs_n_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                 rw_q;
  logic [7:0]           len_q;
  logic                 lat2_q;
  logic [7:0]           rdata_q;
  logic                 rvalid_q;

  logic                 accept;
  logic                 sel_onehot;
  logic [MODULES-1:0]   sel;
  logic [63:0]          addr_ext;
  logic [31:0]          waddr;
  logic [47:0]          ca;
  logic [47:0]          ca_sh;
  logic [7:0]           lat_last;
  logic                 data_rd;

  assign accept     = (state_q == StIdle) && req_valid_i;
  assign sel        = ~cs_mask_i;
  assign sel_onehot = (sel != '0) && ((sel & (sel - MODULES'(1))) == '0);

  // Word address is the byte address halved; an odd byte address starts at the same word.
  assign addr_ext = 64'(addr_q);
  assign waddr    = addr_ext[32:1];
  assign ca       = {rw_q, 1'b0, 1'b1, waddr[31:3], 13'd0, waddr[2:0]};
  assign ca_sh    = ca << {cnt_q[2:0], 3'b000};
  assign lat_last = lat2_q ? Lat2Last : LatLast;
  assign data_rd  = (state_q == StData) && rw_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hb_cs_n_d = hb_cs_n_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          cnt_d = '0;
          if (sel_onehot) begin
            state_d   = StCa;
            hb_cs_n_d = cs_mask_i;
          end else begin
            state_d = StRecov;
          end
        end
      end
      StCa: begin
        if (cnt_q == CaLast) begin
          cnt_d   = '0;
          state_d = StLat;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StLat: begin
        if (cnt_q == lat_last) begin
          cnt_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StData: begin
        if (cnt_q == len_q) begin
          cnt_d     = '0;
          state_d   = StRecov;
          hb_cs_n_d = '1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StRecov: begin
        if (cnt_q == RecovLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = StIdle;
        cnt_d     = '0;
        hb_cs_n_d = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hb_cs_n_q <= '1;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      len_q     <= '0;
      lat2_q    <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hb_cs_n_q <= hb_cs_n_d;
      if (accept) begin
        addr_q <= addr_i;
        rw_q   <= rw_i;
        len_q  <= len_i;
      end
      // RWDS only carries the latency flag during the first CA cycle.
      if ((state_q == StCa) && (cnt_q == '0)) begin
        lat2_q <= hb_rwds_i;
      end
      if (data_rd) begin
        rdata_q <= hb_dq_i;
      end
      rvalid_q <= data_rd;
    end
  end

  always_comb begin
    hb_dq_o    = '0;
    hb_dq_oe_o = 1'b0;
    wready_o   = 1'b0;
    if (state_q == StCa) begin
      hb_dq_o    = ca_sh[47:40];
      hb_dq_oe_o = 1'b1;
    end else if ((state_q == StData) && !rw_q) begin
      hb_dq_o    = wdata_i;
      hb_dq_oe_o = 1'b1;
      wready_o   = 1'b1;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign hb_cs_n_o   = hb_cs_n_q;
  assign rdata_o     = rdata_q;
  assign rvalid_o    = rvalid_q;

endmodule

// File: tb/tb_hyperbus_ca_seq.sv
// Self-checking bench for hyperbus_ca_seq: cycle-indexed reference timeline plus byte scoreboards
// for CA/write bytes on DQ and for read bytes returned on rdata_o.
module tb_hyperbus_ca_seq;

  localparam int unsigned MODULES    = 4;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned LATENCY    = 6;
  localparam int unsigned RECOVERY   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [MODULES-1:0]    cs_mask_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic                  rw_i;
  logic [7:0]            len_i;
  logic [7:0]            wdata_i;
  logic                  wready_o;
  logic [7:0]            rdata_o;
  logic                  rvalid_o;
  logic [MODULES-1:0]    hb_cs_n_o;
  logic [7:0]            hb_dq_o;
  logic                  hb_dq_oe_o;
  logic [7:0]            hb_dq_i;
  logic                  hb_rwds_i;
  logic                  busy_o;

  int errors = 0;
  int checks = 0;
  logic [7:0] dq_q[$];
  logic [7:0] rd_q[$];

  always #5 clk = ~clk;

  hyperbus_ca_seq #(
    .MODULES   (MODULES),
    .ADDR_WIDTH(ADDR_WIDTH),
    .LATENCY   (LATENCY),
    .RECOVERY  (RECOVERY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .cs_mask_i  (cs_mask_i),
    .addr_i     (addr_i),
    .rw_i       (rw_i),
    .len_i      (len_i),
    .wdata_i    (wdata_i),
    .wready_o   (wready_o),
    .rdata_o    (rdata_o),
    .rvalid_o   (rvalid_o),
    .hb_cs_n_o  (hb_cs_n_o),
    .hb_dq_o    (hb_dq_o),
    .hb_dq_oe_o (hb_dq_oe_o),
    .hb_dq_i    (hb_dq_i),
    .hb_rwds_i  (hb_rwds_i),
    .busy_o     (busy_o)
  );

  task automatic test_reset();
    rst = 1'b1; req_valid_i = 1'b0; cs_mask_i = '1; addr_i = '0; rw_i = 1'b0; len_i = '0;
    wdata_i = '0; hb_dq_i = '0; hb_rwds_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (hb_cs_n_o !== 4'hF) begin errors++; $display("FAIL reset_cs got=%h exp=f", hb_cs_n_o); end
    checks++; if (hb_dq_oe_o !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b exp=0", hb_dq_oe_o); end
    checks++; if (hb_dq_o !== 8'h00) begin errors++; $display("FAIL reset_dq got=%h exp=00", hb_dq_o); end
    checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", rvalid_o); end
    checks++; if (rdata_o !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", rdata_o); end
    checks++; if (wready_o !== 1'b0) begin errors++; $display("FAIL reset_wready got=%b exp=0", wready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
  endtask

  // Runs one request and checks every cycle against the timeline derived from the request.
  task automatic run_txn(input logic [3:0] mask, input logic [31:0] addr, input logic rw,
                         input logic [7:0] len, input logic rwds, input logic [47:0] ca,
                         input string name);
    int zeros, lat, active, nwr, nrv;
    bit valid, in_data, rv_exp, oe_exp;
    logic [3:0] cs_exp;
    logic [7:0] b;
    zeros = 0;
    for (int i = 0; i < 4; i++) if (!mask[i]) zeros++;
    valid  = (zeros == 1);
    lat    = rwds ? 2 * LATENCY : LATENCY;
    active = valid ? 6 + lat + int'(len) + 1 : 0;
    nwr = 0; nrv = 0;
    @(negedge clk);
    req_valid_i = 1'b1; cs_mask_i = mask; addr_i = addr; rw_i = rw; len_i = len;
    hb_rwds_i = rwds;
    if (valid) for (int i = 0; i < 6; i++) dq_q.push_back(ca[47-8*i -: 8]);
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL %s ready_at_req got=%b exp=1", name, req_ready_o); end
    for (int k = 1; k <= active + int'(RECOVERY) + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid_i = 1'b0; cs_mask_i = 4'($urandom); addr_i = $urandom; rw_i = 1'($urandom);
        len_i = 8'($urandom);
      end
      if (k == 2) hb_rwds_i = ~rwds;
      hb_dq_i = 8'($urandom); wdata_i = 8'($urandom);
      in_data = valid && (k > 6 + lat) && (k <= active);
      if (in_data && rw) rd_q.push_back(hb_dq_i);
      if (in_data && !rw) dq_q.push_back(wdata_i);
      #1;
      cs_exp = (k <= active) ? mask : 4'hF;
      oe_exp = valid && (k <= 6 || (in_data && !rw));
      rv_exp = valid && rw && (k > 6 + lat + 1) && (k <= active + 1);
      checks++; if (hb_cs_n_o !== cs_exp) begin errors++; $display("FAIL %s cs k=%0d got=%h exp=%h", name, k, hb_cs_n_o, cs_exp); end
      checks++; if (busy_o !== (k <= active + int'(RECOVERY))) begin errors++; $display("FAIL %s busy k=%0d got=%b", name, k, busy_o); end
      checks++; if (req_ready_o !== (k > active + int'(RECOVERY))) begin errors++; $display("FAIL %s ready k=%0d got=%b", name, k, req_ready_o); end
      checks++; if (hb_dq_oe_o !== oe_exp) begin errors++; $display("FAIL %s oe k=%0d got=%b exp=%b", name, k, hb_dq_oe_o, oe_exp); end
      checks++; if (wready_o !== (in_data && !rw)) begin errors++; $display("FAIL %s wready k=%0d got=%b", name, k, wready_o); end
      checks++; if (rvalid_o !== rv_exp) begin errors++; $display("FAIL %s rvalid k=%0d got=%b exp=%b", name, k, rvalid_o, rv_exp); end
      if (wready_o) nwr++;
      if (rvalid_o) nrv++;
      if (oe_exp) begin
        b = (dq_q.size() > 0) ? dq_q.pop_front() : 8'hxx;
        checks++; if (hb_dq_o !== b) begin errors++; $display("FAIL %s dq k=%0d got=%h exp=%h", name, k, hb_dq_o, b); end
      end
      if (rv_exp) begin
        b = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hxx;
        checks++; if (rdata_o !== b) begin errors++; $display("FAIL %s rdata k=%0d got=%h exp=%h", name, k, rdata_o, b); end
      end
    end
    checks++; if (nwr !== ((valid && !rw) ? int'(len) + 1 : 0)) begin errors++; $display("FAIL %s wready_count got=%0d", name, nwr); end
    checks++; if (nrv !== ((valid && rw) ? int'(len) + 1 : 0)) begin errors++; $display("FAIL %s rvalid_count got=%0d", name, nrv); end
    checks++; if (dq_q.size() + rd_q.size() != 0) begin errors++; $display("FAIL %s leftover got=%0d exp=0", name, dq_q.size() + rd_q.size()); end
    dq_q.delete(); rd_q.delete();
  endtask

  task automatic test_write();
    run_txn(4'b1101, 32'h0000_0010, 1'b0, 8'd3, 1'b0, 48'h2000_0001_0000, "write_basic");
    run_txn(4'b1110, 32'hFFFF_FFFF, 1'b0, 8'd1, 1'b1, 48'h2FFF_FFFF_0007, "write_maxaddr");
  endtask

  task automatic test_read();
    run_txn(4'b0111, 32'h0000_0002, 1'b1, 8'd0, 1'b1, 48'hA000_0000_0001, "read_lat2");
    run_txn(4'b1011, 32'h0000_0040, 1'b1, 8'd5, 1'b0, 48'hA000_0004_0000, "read_lat1");
  endtask

  task automatic test_invalid_mask();
    run_txn(4'b1111, 32'h0000_0100, 1'b0, 8'd7, 1'b0, 48'h0, "mask_none");
    run_txn(4'b1100, 32'h0000_0100, 1'b1, 8'd2, 1'b0, 48'h0, "mask_two");
    run_txn(4'b0000, 32'h0000_0100, 1'b1, 8'd2, 1'b1, 48'h0, "mask_zero");
  endtask

  task automatic test_long_read();
    run_txn(4'b1101, 32'h1234_5679, 1'b1, 8'd255, 1'b1, 48'hA123_4567_0004, "read_len256");
    run_txn(4'b1110, 32'h0000_0008, 1'b0, 8'd0, 1'b0, 48'h2000_0000_0004, "after_long");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid_i = 1'b1; cs_mask_i = 4'b1110; addr_i = 32'h80; rw_i = 1'b1; len_i = 8'd3;
    hb_rwds_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req_valid_i = 1'b0;
    end
    #1;
    checks++; if (hb_cs_n_o !== 4'b1110) begin errors++; $display("FAIL abort_pre_cs got=%h exp=e", hb_cs_n_o); end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (hb_cs_n_o !== 4'hF) begin errors++; $display("FAIL abort_cs got=%h exp=f", hb_cs_n_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
    checks++; if (rdata_o !== 8'h00) begin errors++; $display("FAIL abort_rdata got=%h exp=00", rdata_o); end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", req_ready_o); end
    checks++; if (hb_cs_n_o !== 4'hF) begin errors++; $display("FAIL abort_cs_after got=%h exp=f", hb_cs_n_o); end
    run_txn(4'b0111, 32'h0000_0004, 1'b1, 8'd1, 1'b0, 48'hA000_0000_0002, "after_abort");
  endtask

  task automatic test_back_to_back();
    int runs, gap, mingap, runlen;
    bit low, prev;
    int lens[$];
    runs = 0; gap = 0; mingap = 1000; runlen = 0; prev = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b1; cs_mask_i = 4'b1011; addr_i = 32'h20; rw_i = 1'b0; len_i = 8'd0;
    hb_rwds_i = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk); #1;
      low = (hb_cs_n_o != 4'hF);
      if (low && !prev) begin
        runs++;
        if (runs == 2) begin mingap = gap; req_valid_i = 1'b0; end
        runlen = 0; gap = 0;
      end
      if (low) runlen++;
      if (!low && prev) lens.push_back(runlen);
      if (!low && runs >= 1) gap++;
      if (low && hb_cs_n_o !== 4'b1011) begin
        errors++; $display("FAIL b2b_cs got=%h exp=b", hb_cs_n_o);
      end
      prev = low;
    end
    checks++; if (runs != 2) begin errors++; $display("FAIL b2b_runs got=%0d exp=2", runs); end
    checks++; if (mingap < int'(RECOVERY) + 1) begin errors++; $display("FAIL b2b_gap got=%0d exp>=%0d", mingap, RECOVERY + 1); end
    checks++; if (lens.size() != 2) begin errors++; $display("FAIL b2b_nlens got=%0d exp=2", lens.size()); end
    foreach (lens[i]) begin
      checks++; if (lens[i] != 13) begin errors++; $display("FAIL b2b_len%0d got=%0d exp=13", i, lens[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_invalid_mask();
    test_long_read();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
